// File: rtl/spi_slave_port_if.sv
// SPI pin and reply/receive handshake bundle for one chip-select endpoint.
interface spi_slave_port_if #(
   parameter int DATA_W = 8
);
   logic              sclk;
   logic              cs_n;
   logic              mosi;
   logic              miso;
   logic              miso_oe;
   logic [DATA_W-1:0] tx_data;
   logic              tx_load;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
   logic              overrun;

   modport slave (
      input  sclk, cs_n, mosi, tx_data, tx_load,
      output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun
   );

   modport master (
      output sclk, cs_n, mosi, tx_data, tx_load,
      input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, overrun
   );
endinterface

// File: rtl/spi_slave_port.sv
// SPI slave endpoint, LSB first, mosi sampled on sclk fall; rx_valid SYNC_STAGES+2 clk after last fall at pin.
// No backpressure on rx (1-cycle strobe); reply buffer accepts tx_load only while tx_ready=1.
module spi_slave_port #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset,
   spi_slave_port_if.slave bus
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, cs_prev_q;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_fall, cs_fall, cs_rise;
   logic [DATA_W-1:0]      tx_buf_q, tx_buf_d;
   logic [DATA_W-1:0]      shift_tx_q, shift_tx_d;
   logic [DATA_W-1:0]      shift_rx_q, shift_rx_d;
   logic [DATA_W-1:0]      rx_data_q, rx_data_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   miso_q, miso_d;
   logic                   done_q, done_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   overrun_q, overrun_d;
   logic                   tx_ready;

   // cs_n synchronizer resets high so reset release never fakes a select edge
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_fall = sclk_prev_q & ~sclk_s;
   assign cs_fall   = cs_prev_q & ~cs_s;
   assign cs_rise   = ~cs_prev_q & cs_s;
   assign tx_ready  = (state_q != ACTIVE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_buf_q   <= '0;
         shift_tx_q <= '0;
         shift_rx_q <= '0;
         rx_data_q  <= '0;
         cnt_q      <= '0;
         miso_q     <= 1'b0;
         done_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_buf_q   <= tx_buf_d;
         shift_tx_q <= shift_tx_d;
         shift_rx_q <= shift_rx_d;
         rx_data_q  <= rx_data_d;
         cnt_q      <= cnt_d;
         miso_q     <= miso_d;
         done_q     <= done_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tx_buf_d   = tx_buf_q;
      shift_tx_d = shift_tx_q;
      shift_rx_d = shift_rx_q;
      rx_data_d  = rx_data_q;
      cnt_d      = cnt_q;
      miso_d     = miso_q;
      done_d     = 1'b0;
      rx_valid_d = 1'b0;
      overrun_d  = overrun_q;

      if (bus.tx_load && tx_ready) begin
         tx_buf_d = bus.tx_data;
      end

      // shift_rx_q still holds the finished word here even if a new frame starts this cycle
      if (done_q) begin
         rx_data_d  = shift_rx_q;
         rx_valid_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               shift_tx_d = tx_buf_q;
               cnt_d      = '0;
               miso_d     = tx_buf_q[0];
               state_d    = ACTIVE;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               miso_d  = 1'b0;
               state_d = IDLE;
            end else if (sclk_fall) begin
               shift_rx_d = {mosi_s, shift_rx_q[DATA_W-1:1]};
               shift_tx_d = shift_tx_q >> 1;
               miso_d     = shift_tx_q[1];
               cnt_d      = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  done_d    = 1'b1;
                  overrun_d = overrun_q | done_q | rx_valid_q;
                  state_d   = DONE;
               end
            end
         end
         DONE: begin
            if (cs_rise) begin
               miso_d  = 1'b0;
               state_d = IDLE;
            end else if (sclk_fall) begin
               // this fall is bit 0 of a back-to-back frame; the master already sampled miso
               shift_rx_d = {mosi_s, shift_rx_q[DATA_W-1:1]};
               shift_tx_d = tx_buf_q >> 1;
               miso_d     = tx_buf_q[1];
               cnt_d      = CNT_W'(1);
               state_d    = ACTIVE;
            end
         end
         default: begin
            miso_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.miso     = miso_q;
   assign bus.miso_oe  = (state_q != IDLE);
   assign bus.tx_ready = tx_ready;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.busy     = (state_q == ACTIVE);
   assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_spi_slave_port.sv
// Directed-sequence bench with random words for spi_slave_port, acting as SPI master and reply loader.
module tb_spi_slave_port;
   localparam int W    = 8;
   localparam int HALF = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   spi_slave_port_if #(.DATA_W(W)) bus();

   spi_slave_port #(.DATA_W(W), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // receive-side observer: counts strobes, keeps last word, flags long strobes/overrun
   int         rx_cnt   = 0;
   logic [W-1:0] rx_last = '0;
   int         vld_run  = 0;
   int         vld_long = 0;
   int         ovr_seen = 0;
   always @(negedge clk) begin
      if (bus.rx_valid === 1'b1) begin
         if (vld_run == 0) begin
            rx_cnt  <= rx_cnt + 1;
            rx_last <= bus.rx_data;
         end else begin
            vld_long <= vld_long + 1;
         end
         vld_run <= vld_run + 1;
      end else begin
         vld_run <= 0;
      end
      if (bus.overrun === 1'b1) ovr_seen <= ovr_seen + 1;
   end

   // reference model state: reply buffer contents and count of completed frames
   logic [W-1:0] mbuf;
   int           exp_rx;
   logic [W-1:0] m_tx, m_rx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string p);
      check({p, "_miso"},     32'(bus.miso),     32'd0);
      check({p, "_miso_oe"},  32'(bus.miso_oe),  32'd0);
      check({p, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
      check({p, "_rx_data"},  32'(bus.rx_data),  32'd0);
      check({p, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
      check({p, "_busy"},     32'(bus.busy),     32'd0);
      check({p, "_overrun"},  32'(bus.overrun),  32'd0);
   endtask

   task automatic clock_bits(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         bus.sclk = 1'b1;
         bus.mosi = m_tx[i];
         repeat (HALF) @(negedge clk);
         bus.sclk = 1'b0;
         m_rx[i]  = bus.miso;
         repeat (HALF) @(negedge clk);
      end
   endtask

   task automatic sel();
      bus.cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      check("sel_miso_oe", 32'(bus.miso_oe), 32'd1);
   endtask

   task automatic desel();
      bus.cs_n = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   task automatic load(input logic [W-1:0] w, input bit accept);
      check("load_tx_ready", 32'(bus.tx_ready), 32'(accept));
      bus.tx_data = w;
      bus.tx_load = 1'b1;
      @(negedge clk);
      bus.tx_load = 1'b0;
      @(negedge clk);
      if (accept) mbuf = w;
   endtask

   task automatic wait_rx(input string tag);
      int k = 0;
      while (rx_cnt < exp_rx && k < 40) begin
         @(negedge clk);
         k++;
      end
      check(tag, 32'(rx_cnt), 32'(exp_rx));
   endtask

   // one selected frame; reply is the buffer, except bit0 reads 0 when continuing back-to-back
   task automatic frame(input logic [W-1:0] w, input bit cont, input string tag);
      m_tx = w;
      clock_bits(0, W - 1);
      exp_rx++;
      wait_rx({tag, "_rxcnt"});
      check({tag, "_rxdata"}, 32'(rx_last), 32'(w));
      check({tag, "_reply"},  32'(m_rx), 32'(cont ? (mbuf & 8'hFE) : mbuf));
   endtask

   task automatic xfer(input logic [W-1:0] w, input string tag);
      sel();
      frame(w, 1'b0, tag);
      desel();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] w, t, keep_data;
      bus.sclk = 1'b0; bus.cs_n = 1'b1; bus.mosi = 1'b0;
      bus.tx_load = 1'b0; bus.tx_data = '0;
      mbuf = '0; exp_rx = 0; m_tx = '0; m_rx = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check_reset_vals("idle");

      // basic frame
      load(8'hA5, 1'b1);
      xfer(8'h3C, "basic");
      check("basic_busy_after", 32'(bus.busy), 32'd0);

      // random single frames
      for (int n = 0; n < 6; n++) begin
         t = W'($urandom); w = W'($urandom);
         load(t, 1'b1);
         xfer(w, "rand");
      end

      // back-to-back: directed then random
      for (int n = 0; n < 2; n++) begin
         load((n == 0) ? W'($urandom) : W'($urandom), 1'b1);
         sel();
         frame((n == 0) ? 8'h01 : W'($urandom), 1'b0, "b2b_first");
         check("b2b_done_busy", 32'(bus.busy), 32'd0);
         check("b2b_done_oe", 32'(bus.miso_oe), 32'd1);
         load((n == 0) ? 8'h5A : W'($urandom), 1'b1);
         frame((n == 0) ? 8'hFE : W'($urandom), 1'b1, "b2b_second");
         desel();
      end

      // abort after 5 bits
      t = W'($urandom);
      load(t, 1'b1);
      sel();
      m_tx = W'($urandom);
      clock_bits(0, 4);
      bus.cs_n = 1'b1;
      repeat (20) @(negedge clk);
      check("abort_no_rx", 32'(rx_cnt), 32'(exp_rx));
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_oe", 32'(bus.miso_oe), 32'd0);
      check("abort_tx_ready", 32'(bus.tx_ready), 32'd1);
      xfer(W'($urandom), "after_abort");

      // load gating while busy, then resend without reload
      t = W'($urandom);
      load(t, 1'b1);
      sel();
      m_tx = W'($urandom);
      w = m_tx;
      clock_bits(0, 2);
      check("gate_busy", 32'(bus.busy), 32'd1);
      load(8'hFF, 1'b0);
      clock_bits(3, W - 1);
      exp_rx++;
      wait_rx("gate_rxcnt");
      check("gate_rxdata", 32'(rx_last), 32'(w));
      check("gate_reply", 32'(m_rx), 32'(t));
      desel();
      xfer(W'($urandom), "resend");

      // mid-frame reset
      load(W'($urandom), 1'b1);
      sel();
      m_tx = W'($urandom);
      clock_bits(0, 2);
      reset = 1'b1; bus.cs_n = 1'b1; bus.sclk = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");
      reset = 1'b0;
      mbuf = '0;
      repeat (20) @(negedge clk);
      check("midrst_no_rx", 32'(rx_cnt), 32'(exp_rx));
      xfer(W'($urandom), "post_reset");

      // deselected: sclk toggles with cs_n high
      keep_data = bus.rx_data;
      m_tx = W'($urandom);
      for (int i = 0; i < W; i++) begin
         clock_bits(i, i);
         check("desel_oe", 32'(bus.miso_oe), 32'd0);
      end
      repeat (20) @(negedge clk);
      check("desel_no_rx", 32'(rx_cnt), 32'(exp_rx));
      check("desel_rx_data", 32'(bus.rx_data), 32'(keep_data));

      check("strobe_width", 32'(vld_long), 32'd0);
      check("overrun_never", 32'(ovr_seen), 32'd0);
      check("overrun_final", 32'(bus.overrun), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
